// File: rtl/bit_permute_pipe.sv
// Purpose : two-stage bit-permutation unit (pass / full reverse / group reverse /
//           half swap) with a parallel leading-zero count of the original operand.
// Latency : 2 cycles from input handshake to out_valid; one transaction per cycle.
// Backpressure: valid/ready per stage; a stalled stage holds its registers, and
//           in_ready drops only when both stages are full and out_ready is low.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake; in_data operand, in_mode permutation
//   out_valid/out_ready    downstream handshake
//   out_data               permuted operand
//   out_lzc, out_zero      leading-zero count / all-zero flag of the original operand
module bit_permute_pipe #(
    parameter int WIDTH = 23,
    parameter int GROUP = 8,
    localparam int LZW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LZW-1:0]   out_lzc,
    output logic             out_zero
);

    // Half split shared by the half-swap permutation and the two-part LZC.
    localparam int H    = WIDTH / 2;
    localparam int LO_W = H;
    localparam int HI_W = WIDTH - H;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_GRP  = 2'b10;
    localparam logic [1:0] MODE_HSW  = 2'b11;

    // Source bit for output bit i in group-reverse mode. Groups start at bit 0;
    // the top group may be short and is mirrored within its own size.
    function automatic int grp_src(input int i);
        int base;
        int size;
        base = (i / GROUP) * GROUP;
        size = ((WIDTH - base) < GROUP) ? (WIDTH - base) : GROUP;
        return base + size - 1 - (i - base);
    endfunction

    // Leading zeros within the upper part; HI_W when the part is empty of ones.
    function automatic logic [LZW-1:0] lzc_hi(input logic [HI_W-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(HI_W);
        // Scanning upward, the highest set bit is the last one to overwrite n.
        for (int i = 0; i < HI_W; i++) begin
            if (v[i]) n = LZW'(HI_W - 1 - i);
        end
        return n;
    endfunction

    function automatic logic [LZW-1:0] lzc_lo(input logic [LO_W-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(LO_W);
        for (int i = 0; i < LO_W; i++) begin
            if (v[i]) n = LZW'(LO_W - 1 - i);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_v;
    logic s2_v;
    logic s1_adv;
    logic s2_adv;
    logic accept;

    assign s2_adv   = !s2_v || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1 combinational: permutation and per-half LZC summaries
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] perm;
    logic [WIDTH-1:0] full_rev;
    logic [WIDTH-1:0] grp_rev;
    logic [WIDTH-1:0] half_swap;
    logic [HI_W-1:0]  in_hi;
    logic [LO_W-1:0]  in_lo;

    assign in_hi     = in_data[WIDTH-1:H];
    assign in_lo     = in_data[H-1:0];
    assign half_swap = {in_lo, in_hi};

    always_comb begin
        full_rev = '0;
        grp_rev  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            full_rev[i] = in_data[WIDTH-1-i];
            grp_rev[i]  = in_data[grp_src(i)];
        end
    end

    always_comb begin
        perm = in_data;
        unique case (in_mode)
            MODE_PASS: perm = in_data;
            MODE_REV:  perm = full_rev;
            MODE_GRP:  perm = grp_rev;
            MODE_HSW:  perm = half_swap;
            default:   perm = in_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s1_data;
    logic             s1_zero;
    logic             s1_hi_any;
    logic [LZW-1:0]   s1_hi_lzc;
    logic [LZW-1:0]   s1_lo_lzc;

    logic [WIDTH-1:0] s2_data;
    logic [LZW-1:0]   s2_lzc;
    logic             s2_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_data   <= '0;
            s1_zero   <= 1'b0;
            s1_hi_any <= 1'b0;
            s1_hi_lzc <= '0;
            s1_lo_lzc <= '0;
            s2_v      <= 1'b0;
            s2_data   <= '0;
            s2_lzc    <= '0;
            s2_zero   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v <= accept;
                if (accept) begin
                    s1_data   <= perm;
                    s1_zero   <= (in_data == '0);
                    s1_hi_any <= |in_hi;
                    s1_hi_lzc <= lzc_hi(in_hi);
                    s1_lo_lzc <= lzc_lo(in_lo);
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_data <= s1_data;
                    s2_zero <= s1_zero;
                    // Any one in the upper half decides the count; otherwise the
                    // whole upper half is zeros and the lower half continues it.
                    s2_lzc  <= s1_hi_any ? s1_hi_lzc : (LZW'(HI_W) + s1_lo_lzc);
                end
            end
        end
    end

    assign out_valid = s2_v;
    assign out_data  = s2_data;
    assign out_lzc   = s2_lzc;
    assign out_zero  = s2_zero;

endmodule

// File: tb/tb_bit_permute_pipe.sv
module tb_bit_permute_pipe;

    localparam int W   = 23;
    localparam int G   = 8;
    localparam int H   = W / 2;
    localparam int LZW = $clog2(W + 1);

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [1:0]     in_mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [LZW-1:0] out_lzc;
    logic           out_zero;

    bit_permute_pipe #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lzc(out_lzc), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           lzc;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    int accepts = 0;
    bit acc_seen = 0;
    bit lat_chk = 0;

    bit           ovr_en = 0;
    logic [W-1:0] ovr_data;
    int           ovr_lzc;
    logic         ovr_zero;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] m_perm(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] r;
        logic [63:0]  v;
        r = d;
        case (m)
            2'b01: for (int i = 0; i < W; i++) r[i] = d[W-1-i];
            2'b11: begin
                // Rotate right by H: low H bits move to the top.
                v = 64'(d);
                v = (v >> H) | (v << (W - H));
                r = v[W-1:0];
            end
            2'b10: for (int i = 0; i < W; i++) begin
                int b;
                int s;
                b = (i / G) * G;
                s = (W - b < G) ? (W - b) : G;
                r[i] = d[b + s - 1 - (i - b)];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int m_lzc(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) return W - 1 - i;
        end
        return W;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        acc_seen = 0;
        if (!rst) begin
            if (out_valid && !out_ready && q.size() > 0) begin
                chk("hold_data", 64'(out_data), 64'(q[0].data));
                chk("hold_lzc", 64'(out_lzc), 64'(q[0].lzc));
            end
            if (out_valid && out_ready) begin
                pops++;
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_lzc", 64'(out_lzc), 64'(e.lzc));
                    chk("out_zero", 64'(out_zero), 64'(e.zero));
                    if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'(2));
                end
            end
            if (in_valid && in_ready) begin
                if (ovr_en) begin
                    e.data = ovr_data;
                    e.lzc  = ovr_lzc;
                    e.zero = ovr_zero;
                end else begin
                    e.data = m_perm(in_data, in_mode);
                    e.lzc  = m_lzc(in_data);
                    e.zero = (in_data == '0);
                end
                e.acc = cyc;
                q.push_back(e);
                acc_seen = 1;
                accepts++;
            end
        end
    endtask

    // Sample at the falling edge, then advance past the next rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] m, input bit use_ovr,
                        input logic [W-1:0] ed, input int el, input logic ez);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        ovr_en   = use_ovr;
        ovr_data = ed;
        ovr_lzc  = el;
        ovr_zero = ez;
        for (int k = 0; k < 20; k++) begin
            step();
            if (acc_seen) break;
        end
        chk("accept", 64'(acc_seen), 64'(1));
        in_valid = 1'b0;
        ovr_en   = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && q.size() > 0; k++) step();
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    // ---------------- directed vectors ----------------
    logic [W-1:0] dv_in  [5] = '{23'h000001, 23'h000000, 23'h7FF800, 23'h000001, 23'h400000};
    logic [1:0]   dv_md  [5] = '{2'b01,      2'b00,      2'b11,      2'b10,      2'b10};
    logic [W-1:0] dv_out [5] = '{23'h400000, 23'h000000, 23'h000FFF, 23'h000080, 23'h010000};
    int           dv_lzc [5] = '{22,         23,         0,          22,         0};
    logic         dv_zero[5] = '{1'b0,       1'b1,       1'b0,       1'b0,       1'b0};

    logic [W-1:0] bp_data[4];
    int           k_acc;
    int           cnt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        #1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_lzc", 64'(out_lzc), 64'(0));
        chk("rst_out_zero", 64'(out_zero), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed single transactions with exact latency
        out_ready = 1'b1;
        lat_chk   = 1;
        for (int i = 0; i < 5; i++) begin
            send(dv_in[i], dv_md[i], 1, dv_out[i], dv_lzc[i], dv_zero[i]);
            drain();
        end

        // Backpressure: four offered back-to-back into a stalled sink
        lat_chk   = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bp_data[i] = W'($urandom);
        k_acc   = 0;
        accepts = 0;
        in_mode = 2'b01;
        for (int c = 0; c < 6; c++) begin
            in_valid = (k_acc < 4);
            in_data  = bp_data[k_acc < 4 ? k_acc : 3];
            step();
            if (acc_seen) k_acc++;
        end
        chk("bp_accepts", 64'(accepts), 64'(2));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_out_data", 64'(out_data), 64'(m_perm(bp_data[0], 2'b01)));
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (k_acc < 4);
            in_data  = bp_data[k_acc < 4 ? k_acc : 3];
            step();
            if (acc_seen) k_acc++;
        end
        in_valid = 1'b0;
        chk("bp_stream_pops", 64'(pops), 64'(4));
        drain();

        // Reset with two transactions in flight
        out_ready = 1'b0;
        send(23'h123456, 2'b00, 0, '0, 0, 1'b0);
        send(23'h00ABCD, 2'b01, 0, '0, 0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 23'h7FFFFF;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_out_data", 64'(out_data), 64'(0));
        chk("mrst_out_lzc", 64'(out_lzc), 64'(0));
        chk("mrst_out_zero", 64'(out_zero), 64'(0));
        chk("mrst_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) cnt++;
            step();
        end
        chk("mrst_no_output", 64'(cnt), 64'(0));

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            if ($urandom_range(0, 7) == 0) in_data = '0;
            if ($urandom_range(0, 7) == 0) in_data = W'(1) << $urandom_range(0, W - 1);
            in_mode   = 2'($urandom_range(0, 3));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_permute_pipe.md
# bit_permute_pipe

Parametrised, two-stage pipelined bit-permutation unit for the floating-point datapath. It takes a WIDTH-bit mantissa field and a per-transaction mode, and produces one of four outputs: pass-through, full bit reversal, half-swap, or reversal within fixed-size groups. In parallel it computes the input's leading-zero count, which the normaliser uses. Upstream (alignment) and downstream (normalisation) stages connect through a valid/ready handshake, so the block can be stalled without losing data.

## Interface
- WIDTH, 23, data width in bits (≥ 2).
- GROUP, 8, group size for mode 2'b10 (1 ≤ GROUP ≤ WIDTH).
- LZW (localparam), $clog2(WIDTH+1), leading-zero count width (5 for WIDTH=23).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  operand.
- in_mode  in  2  00 pass, 01 full reverse, 10 group reverse, 11 half swap.
- out_valid  out  1  output transaction present.
- out_ready  in  1  downstream accepts output.
- out_data  out  WIDTH  permuted operand.
- out_lzc  out  LZW  leading zeros of in_data counted from MSB; WIDTH when in_data is 0.
- out_zero  out  1  in_data was all zeros.

## Operation
- Permutation, with i indexing out_data:
  - Mode 00: out[i] = in[i].
  - Mode 01: out[i] = in[WIDTH-1-i].
  - Mode 11: H = WIDTH/2 (floor). out = {in[H-1:0], in[WIDTH-1:H]}. For WIDTH=23: {in[10:0], in[22:11]}.
  - Mode 10: bits are split into groups of GROUP bits starting at bit 0. Each group is reversed in place. A final partial group (WIDTH mod GROUP bits at the top) is reversed within its own size.
- Stage 1 (S1): on acceptance, registers the permuted data, the zero flag, and a per-half "any-one" summary for the LZC.
- Stage 2 (S2): registers the data unchanged and completes the leading-zero count.
- out_lzc and out_zero always describe the original in_data, independent of mode.
- Each stage holds a valid bit (s1_v, s2_v):
  - s2_adv = !s2_v | out_ready.
  - s1_adv = !s1_v | s2_adv.
  - in_ready = s1_adv (combinational; no path from in_valid).
- Accept when in_valid & in_ready. S1 loads and s1_v ← 1. If s1_adv but no accept, s1_v ← 0.
- S2 loads from S1 when s2_adv & s1_v, then s2_v ← 1. If s2_adv & !s1_v, s2_v ← 0.
- out_valid = s2_v. Outputs are driven from S2 registers only.
- While a stage is stalled its registers hold; out_data, out_lzc and out_zero are stable while out_valid & !out_ready.
- Transactions leave in acceptance order; none are dropped or duplicated.

## Timing
- Latency: 2 cycles. An input accepted at edge N is valid at out_* after edge N+2 (visible in cycle N+2) when downstream is not stalling.
- Throughput: one transaction per cycle while out_ready = 1.
- Reset (synchronous, takes effect at the next edge regardless of other inputs):
  - s1_v, s2_v ← 0.
  - out_valid = 0; out_data = 0, out_lzc = 0, out_zero = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-stream discards both in-flight transactions. No output is produced for them.
- Full condition (s1_v & s2_v & !out_ready) forces in_ready = 0; no accept occurs.
- Simultaneous output-consume and input-accept in the same cycle is legal; both stages advance.
- Data, mode and in_data are ignored when in_valid = 0. in_mode is sampled only on accept.

## Test plan
- Full reverse (WIDTH=23): in_data=23'h000001, mode 01 -> out_data=23'h400000, out_lzc=22, out_zero=0, out_valid exactly 2 cycles after accept.
- Zero operand: in_data=0, mode 00 -> out_data=0, out_lzc=23, out_zero=1.
- Half swap: in_data=23'h7FF800, mode 11 -> out_data=23'h000FFF, out_lzc=0.
- Group reverse (GROUP=8): in_data=23'h000001, mode 10 -> out_data=23'h000080. in_data=23'h400000 (top partial group, 7 bits) -> out_data=23'h010000, out_lzc=0.
- Backpressure: out_ready=0 while 4 back-to-back inputs are offered -> exactly 2 accepted, then in_ready=0 with out_data held. Releasing out_ready yields all 4 in order with no gaps once streaming resumes.
- Reset mid-stream: 2 transactions in flight, rst pulsed for 1 cycle -> out_valid=0, outputs 0 and in_ready=1 the next cycle; neither transaction ever appears at the output.
